// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the single boot ROM read port between the loader (m0) and fetch (m1).
// Optional watchdog enabled by defining ROM_ARB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module rom_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_done,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_read_en,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_read_en,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read_en,
  input  logic [DATA_W-1:0] rom_data_out,
  input  logic              rom_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, next_state;
  logic   grant;
  logic   last_grant;
  logic   elig0, elig1, any_eligible, win;
  logic   timeout_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("rom_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  // Fetch is held off entirely until the loader reports the ROM mapped.
  assign elig0        = m0_read_en;
  assign elig1        = m1_read_en & boot_done;
  assign any_eligible = elig0 | elig1;
  assign win          = (elig0 & elig1) ? ~last_grant : elig1;

`ifdef ROM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] to_cnt;

  assign timeout_hit = (state == ISSUE) && ((to_cnt + 16'd1) == TO_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= to_cnt + 16'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  // A ROM answer in the limit cycle is a normal completion, so no error then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (timeout_hit && !rom_ready) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_eligible) next_state = ISSUE;
      ISSUE:   if (rom_ready || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // RESP is a forced turnaround: the ready pulse drops and no grant is made there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr    <= '0;
      rom_read_en <= 1'b0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_data     <= '0;
      m1_data     <= '0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_eligible) begin
            grant       <= win;
            rom_addr    <= win ? m1_addr : m0_addr;
            rom_read_en <= 1'b1;
          end
        end
        ISSUE: begin
          if (rom_ready || timeout_hit) begin
            rom_read_en <= 1'b0;
            last_grant  <= grant;
            if (grant) begin
              m1_ready <= 1'b1;
              m1_data  <= rom_ready ? rom_data_out : '1;
            end else begin
              m0_ready <= 1'b1;
              m0_data  <= rom_ready ? rom_data_out : '1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: table vectors plus hand-written sequences, with a ready-pulse scoreboard.
`timescale 1ns/1ps
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_done;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_read_en, m1_read_en;
  logic [7:0]  m0_data, m1_data;
  logic        m0_ready, m1_ready;
  logic [31:0] rom_addr;
  logic        rom_read_en;
  logic [7:0]  rom_data_out;
  logic        rom_ready;
  logic        busy;
  logic        err;

  rom_arbiter #(.ADDR_W(32), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .m0_addr(m0_addr), .m0_read_en(m0_read_en), .m0_data(m0_data), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_read_en(m1_read_en), .m1_data(m1_data), .m1_ready(m1_ready),
    .rom_addr(rom_addr), .rom_read_en(rom_read_en), .rom_data_out(rom_data_out),
    .rom_ready(rom_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         port;
    logic [7:0] data;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    bit          boot;
    bit          r0;
    bit          r1;
    logic [31:0] a0;
    logic [31:0] a1;
    int          lat;
    bit          exp_port;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_count = 0;
  int   rom_lat = 1;
  bit   rom_enable = 1'b1;

  function automatic logic [7:0] rom_fn(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h30;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready(output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (m0_ready || m1_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL ready_wait: no ready pulse within %0d cycles, expected one", cycles);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    bit   seen;
    int   cyc;
    exp_t e;
    boot_done  = v.boot;
    m0_addr    = v.a0;
    m1_addr    = v.a1;
    rom_lat    = v.lat;
    m0_read_en = v.r0;
    m1_read_en = v.r1;
    e.port = v.exp_port;
    e.addr = v.exp_port ? v.a1 : v.a0;
    e.data = rom_fn(e.addr);
    sb.push_back(e);
    wait_ready(seen, cyc);
    m0_read_en = 1'b0;
    m1_read_en = 1'b0;
    @(negedge clk);
  endtask

  // ROM model: answers rom_lat cycles after it first sees rom_read_en.
  initial begin : rom_model
    int wait_cnt;
    wait_cnt     = 0;
    rom_ready    = 1'b0;
    rom_data_out = '0;
    forever begin
      @(negedge clk);
      if (rst || rom_ready) begin
        rom_ready = 1'b0;
        wait_cnt  = 0;
      end else if (rom_read_en && rom_enable) begin
        if (wait_cnt >= rom_lat) begin
          rom_ready    = 1'b1;
          rom_data_out = rom_fn(rom_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin : ready_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (m0_ready || m1_ready)) begin
        ready_count++;
        if (m0_ready && m1_ready) check_output("one_ready", 32'(m0_ready & m1_ready), 32'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL unexpected_ready: m0_ready=%0b m1_ready=%0b, expected none", m0_ready, m1_ready);
        end else begin
          e = sb.pop_front();
          check_output("ready_port", 32'(m1_ready), 32'(e.port));
          check_output("ready_data", 32'(m1_ready ? m1_data : m0_data), 32'(e.data));
          check_output("grant_addr", rom_addr, e.addr);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL global_timeout: bench still running, expected finish");
    $fatal(1, "[TB] bench timeout");
  end

  initial begin : main
    vec_t vecs[8];
    vec_t v;
    exp_t e;
    bit   seen, saw_busy;
    int   cyc, rc, c0, c1;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h1,        32'h2, 1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h3,        32'h4, 2, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'h5, 0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h6,        32'h7, 1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h8,        32'h9, 2, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h1234,     32'h0, 2, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'hA,        32'hB, 0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'hC, 3, 1'b0};

    rst = 1'b1; boot_done = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_read_en = 1'b0; m1_read_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    check_output("rst_rom_read_en", 32'(rom_read_en), 32'd0);
    check_output("rst_rom_addr", rom_addr, 32'd0);
    check_output("rst_m0_ready", 32'(m0_ready), 32'd0);
    check_output("rst_m1_ready", 32'(m1_ready), 32'd0);
    check_output("rst_m0_data", 32'(m0_data), 32'd0);
    check_output("rst_m1_data", 32'(m1_data), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);

    $display("[TB] boot gating");
    boot_done = 1'b0; rom_lat = 3;
    m0_addr = 32'h30; m1_addr = 32'h40; m0_read_en = 1'b1; m1_read_en = 1'b1;
    e = '{port: 1'b0, data: 8'h00, addr: 32'h30};
    sb.push_back(e);
    wait_ready(seen, cyc);
    m0_read_en = 1'b0;
    saw_busy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy || rom_read_en) saw_busy = 1'b1;
    end
    check_output("m1_gated", 32'(saw_busy), 32'd0);
    boot_done = 1'b1;
    e = '{port: 1'b1, data: 8'h70, addr: 32'h40};
    sb.push_back(e);
    wait_ready(seen, cyc);
    m1_read_en = 1'b0;
    @(negedge clk);

    $display("[TB] zero-latency turnaround");
    rom_lat = 0; m0_addr = 32'h55; m0_read_en = 1'b1;
    e = '{port: 1'b0, data: 8'h65, addr: 32'h55};
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk);
    check_output("lat_issue_busy", 32'(busy), 32'd1);
    check_output("lat_issue_rd", 32'(rom_read_en), 32'd1);
    @(negedge clk);
    check_output("lat_resp_ready", 32'(m0_ready), 32'd1);
    check_output("lat_resp_data", 32'(m0_data), 32'h65);
    check_output("lat_resp_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_output("lat_idle_busy", 32'(busy), 32'd0);
    check_output("lat_idle_ready", 32'(m0_ready), 32'd0);
    @(negedge clk);
    check_output("lat_regrant_busy", 32'(busy), 32'd1);
    wait_ready(seen, cyc);
    m0_read_en = 1'b0;
    @(negedge clk);

    $display("[TB] address stability");
    boot_done = 1'b1; rom_lat = 3; m1_addr = 32'h100; m1_read_en = 1'b1;
    e = '{port: 1'b1, data: 8'h21, addr: 32'h100};
    sb.push_back(e);
    @(negedge clk);
    m1_addr = 32'h200;
    @(negedge clk);
    check_output("addr_hold", rom_addr, 32'h100);
    wait_ready(seen, cyc);
    m1_read_en = 1'b0;
    @(negedge clk);

    $display("[TB] withdrawal");
    rom_lat = 2; m1_addr = 32'hAB; m1_read_en = 1'b1;
    e = '{port: 1'b1, data: 8'h9B, addr: 32'hAB};
    sb.push_back(e);
    @(negedge clk);
    m1_read_en = 1'b0;
    wait_ready(seen, cyc);
    @(negedge clk);

    $display("[TB] reset mid-read");
    rom_lat = 5; m0_addr = 32'h77; m0_read_en = 1'b1;
    rc = ready_count;
    @(negedge clk);
    @(negedge clk);
    check_output("mid_pre_rd", 32'(rom_read_en), 32'd1);
    rst = 1'b1;
    #1;
    check_output("mid_rom_read_en", 32'(rom_read_en), 32'd0);
    check_output("mid_busy", 32'(busy), 32'd0);
    check_output("mid_rom_addr", rom_addr, 32'd0);
    check_output("mid_m0_data", 32'(m0_data), 32'd0);
    check_output("mid_m1_data", 32'(m1_data), 32'd0);
    check_output("mid_m0_ready", 32'(m0_ready), 32'd0);
    m0_read_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_output("mid_no_ready", 32'(ready_count - rc), 32'd0);

    $display("[TB] round-robin");
    boot_done = 1'b1; rom_lat = 1;
    m0_addr = 32'h10; m1_addr = 32'h20; m0_read_en = 1'b1; m1_read_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.port = k[0];
      e.addr = k[0] ? 32'h20 : 32'h10;
      e.data = k[0] ? 8'h10 : 8'h20;
      sb.push_back(e);
    end
    rc = ready_count; c0 = 0; c1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ready(seen, cyc);
      if (m0_ready) c0++;
      if (m1_ready) c1++;
      if (c0 >= 2) m0_read_en = 1'b0;
      if (c1 >= 2) m1_read_en = 1'b0;
    end
    m0_read_en = 1'b0; m1_read_en = 1'b0;
    repeat (4) @(negedge clk);
    check_output("rr_pulses", 32'(ready_count - rc), 32'd4);

`ifdef ROM_ARB_TIMEOUT_EN
    $display("[TB] watchdog");
    rom_enable = 1'b0; m0_addr = 32'h300; m0_read_en = 1'b1;
    e = '{port: 1'b0, data: 8'hFF, addr: 32'h300};
    sb.push_back(e);
    wait_ready(seen, cyc);
    m0_read_en = 1'b0;
    check_output("to_latency", 32'(cyc), 32'd5);
    check_output("to_err_set", 32'(err), 32'd1);
    @(negedge clk);
    rom_enable = 1'b1;
    v = '{1'b1, 1'b1, 1'b0, 32'h3, 32'h0, 1, 1'b0};
    apply_stimulus(v);
    check_output("to_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("to_err_cleared", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
`else
    v = '{1'b1, 1'b0, 1'b1, 32'h0, 32'h3C, 2, 1'b1};
    apply_stimulus(v);
    check_output("err_tied", 32'(err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check_output("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
